// File: rtl/uart_bridge_pkg.sv
// Shared constants and FSM state type for the uart command bridge.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} st_e;

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// Uart byte and register bus signals of the command bridge; master = bridge side.
interface uart_cmd_bridge_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [7:0]        rx_byte;
    logic              rx_stb;
    logic [7:0]        tx_byte;
    logic              tx_req;
    logic              tx_idle;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              busy;
    logic              rx_drop;

    modport master (
        input  rx_byte, rx_stb, tx_idle, bus_rdata, bus_ack,
        output tx_byte, tx_req, bus_req, bus_we, bus_addr, bus_wdata, busy, rx_drop
    );

    modport slave (
        output rx_byte, rx_stb, tx_idle, bus_rdata, bus_ack,
        input  tx_byte, tx_req, bus_req, bus_we, bus_addr, bus_wdata, busy, rx_drop
    );
endinterface

// File: rtl/uart_bridge_txser.sv
// Reply serialiser: shifts out up to NB bytes LSB first, one tx_req per idle transmitter.
module uart_bridge_txser #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              load,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [DATA_W-1:0] data,
    input  logic              tx_idle,
    output logic [7:0]        tx_byte,
    output logic              tx_req,
    output logic              done
);
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic [7:0]        byte_q, byte_d;
    logic              req_q, hold_q, fire;

    // hold_q masks tx_idle for the cycle after a pulse, before the uart has dropped it
    assign fire = (left_q != '0) && tx_idle && !req_q && !hold_q;
    assign done = fire && (left_q == CNT_W'(1));

    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        byte_d  = byte_q;
        if (load) begin
            shreg_d = data;
            left_d  = cnt;
        end else if (fire) begin
            byte_d  = shreg_q[7:0];
            shreg_d = shreg_q >> 8;
            left_d  = left_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            shreg_q <= '0;
            left_q  <= '0;
            byte_q  <= '0;
            req_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            byte_q  <= byte_d;
            req_q   <= fire;
            hold_q  <= req_q;
        end
    end

    assign tx_byte = byte_q;
    assign tx_req  = req_q;
endmodule

// File: rtl/uart_cmd_bridge.sv
// Uart command bridge: parses W/R byte commands, does one bus access, replies over uart.
// Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_,
    uart_cmd_bridge_if.master bif
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(NB) + 1;

    st_e               state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              drop_q, drop_d;
    logic              load, done, tmo_expire;
    logic [CNT_W-1:0]  load_cnt;
    logic [DATA_W-1:0] load_data;

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        tmo_run;

    assign tmo_run    = (state_q == ADDR) || (state_q == WDATA);
    assign tmo_expire = tmo_run && (tmo_q == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tmo_q <= '0;
        end else if (bif.rx_stb || !tmo_run) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYC;
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        drop_d    = 1'b0;
        load      = 1'b0;
        load_cnt  = '0;
        load_data = '0;
        unique case (state_q)
            IDLE: begin
                if (bif.rx_stb) begin
                    if (bif.rx_byte == CMD_WR || bif.rx_byte == CMD_RD) begin
                        is_wr_d = (bif.rx_byte == CMD_WR);
                        state_d = ADDR;
                    end else begin
                        load      = 1'b1;
                        load_cnt  = CNT_W'(1);
                        load_data = DATA_W'(RSP_NAK);
                        state_d   = RESP;
                    end
                end
            end
            ADDR: begin
                // a byte landing in the expiry cycle takes priority over the timeout
                if (bif.rx_stb) begin
                    addr_d  = ADDR_W'(bif.rx_byte);
                    cnt_d   = '0;
                    state_d = is_wr_q ? WDATA : BUS;
                end else if (tmo_expire) begin
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (bif.rx_stb) begin
                    wdata_d[8*cnt_q +: 8] = bif.rx_byte;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        state_d = BUS;
                    end
                end else if (tmo_expire) begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                drop_d = bif.rx_stb;
                if (req_q && bif.bus_ack) begin
                    req_d     = 1'b0;
                    load      = 1'b1;
                    load_cnt  = is_wr_q ? CNT_W'(1) : CNT_W'(NB);
                    load_data = is_wr_q ? DATA_W'(RSP_ACK) : bif.bus_rdata;
                    state_d   = RESP;
                end else begin
                    req_d = 1'b1;
                end
            end
            RESP: begin
                drop_d = bif.rx_stb;
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    uart_bridge_txser #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_txser (
        .clk     (clk),
        .rst_    (rst_),
        .load    (load),
        .cnt     (load_cnt),
        .data    (load_data),
        .tx_idle (bif.tx_idle),
        .tx_byte (bif.tx_byte),
        .tx_req  (bif.tx_req),
        .done    (done)
    );

    assign bif.bus_req   = req_q;
    assign bif.bus_we    = is_wr_q;
    assign bif.bus_addr  = addr_q;
    assign bif.bus_wdata = wdata_q;
    assign bif.busy      = (state_q != IDLE);
    assign bif.rx_drop   = drop_q;
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: command vector table plus drop, reset and timeout sequences.
module tb_uart_cmd_bridge;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [47:0] cmd;    // command bytes, first byte in [7:0]
        int          nb;
        logic [31:0] rdata;
        int          dly;    // ack this many cycles after bus_req rises
        bit          req;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          ntx;
        logic [31:0] tx;     // reply bytes, first byte in [7:0]
    } vec_t;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0]  txq[$];
    logic [7:0]  held;
    int          drops, viol;
    bit          req_seen;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    int          req_cyc, stb_cyc, req_len, ack_dly;
    logic [31:0] rdata_val;
    vec_t        vecs[7];

    uart_cmd_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    uart_cmd_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bif  (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Uart transmitter model: idle drops one cycle after tx_req, stays low 6 cycles
    initial begin
        bif.tx_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (bif.tx_req === 1'b1) begin
                held = bif.tx_byte;
                txq.push_back(held);
                @(negedge clk);
                if (bif.tx_req !== 1'b0 || bif.tx_byte !== held) viol++;
                bif.tx_idle = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (bif.tx_req !== 1'b0 || bif.tx_byte !== held) viol++;
                end
                bif.tx_idle = 1'b1;
            end
        end
    end

    // Bus responder and rx_drop monitor
    initial begin
        int k;
        k = 0;
        bif.bus_ack = 1'b0;
        bif.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bif.rx_drop === 1'b1) drops++;
            if (bif.bus_ack) begin
                bif.bus_ack = 1'b0;
                bif.bus_rdata = $urandom;
                if (bif.bus_req !== 1'b0) viol++;
                k = 0;
            end else if (bif.bus_req === 1'b1) begin
                if (k == 0) begin
                    req_seen  = 1'b1;
                    req_cyc   = cyc;
                    req_we    = bif.bus_we;
                    req_addr  = bif.bus_addr;
                    req_wdata = bif.bus_wdata;
                end else if (bif.bus_we !== req_we || bif.bus_addr !== req_addr ||
                             bif.bus_wdata !== req_wdata) begin
                    viol++;
                end
                k++;
                req_len = k;
                if (k > ack_dly) begin
                    bif.bus_ack = 1'b1;
                    bif.bus_rdata = rdata_val;
                end else begin
                    bif.bus_rdata = $urandom;
                end
            end else begin
                k = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bif.rx_byte = b;
        bif.rx_stb  = 1'b1;
        stb_cyc     = cyc;
        @(negedge clk);
        bif.rx_stb  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input int ntx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bif.busy === 1'b0 && bif.tx_req === 1'b0 && txq.size() == ntx) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic check_tx(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = '0;
        for (int j = 0; j < txq.size() && j < 4; j++) got[8*j +: 8] = txq[j];
        check({tag, " tx bytes"}, got, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        txq.delete();
        drops     = 0;
        viol      = 0;
        req_seen  = 1'b0;
        rdata_val = v.rdata;
        ack_dly   = v.dly;
        for (int j = 0; j < v.nb; j++) send(v.cmd[8*j +: 8]);
        wait_done(v.ntx, ok);
        check({tag, " done"}, ok, 1);
        check({tag, " bus_req seen"}, req_seen, v.req);
        if (v.req) begin
            check({tag, " bus_we"}, req_we, v.we);
            check({tag, " bus_addr"}, req_addr, v.addr);
            check({tag, " req latency"}, req_cyc - stb_cyc, 2);
            check({tag, " req length"}, req_len, v.dly + 1);
            if (v.we) check({tag, " bus_wdata"}, req_wdata, v.wdata);
        end
        check({tag, " tx count"}, txq.size(), v.ntx);
        check_tx(tag, v.tx);
        check({tag, " pacing"}, viol, 0);
        check({tag, " drops"}, drops, 0);
        check({tag, " busy"}, bif.busy, 0);
    endtask

    initial begin
        bit   ok;
        vec_t v;
        vecs[0] = '{48'h1234_5678_1057, 6, 32'h0, 3, 1'b1, 1'b1, 8'h10, 32'h1234_5678, 1, 32'h06};
        vecs[1] = '{48'h0000_0000_2052, 2, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 8'h20, 32'h0, 4,
                    32'hDEAD_BEEF};
        vecs[2] = '{48'h41, 1, 32'h0, 0, 1'b0, 1'b0, 8'h0, 32'h0, 1, 32'h15};
        vecs[3] = '{48'hDDCC_BBAA_0057, 6, 32'h0, 1, 1'b1, 1'b1, 8'h00, 32'hDDCC_BBAA, 1, 32'h06};
        vecs[4] = '{48'h0000_0000_FF52, 2, 32'h0102_0304, 5, 1'b1, 1'b0, 8'hFF, 32'h0, 4,
                    32'h0102_0304};
        vecs[5] = '{48'h00, 1, 32'h0, 0, 1'b0, 1'b0, 8'h0, 32'h0, 1, 32'h15};
        vecs[6] = '{48'h72, 1, 32'h0, 0, 1'b0, 1'b0, 8'h0, 32'h0, 1, 32'h15};

        bif.rx_byte = '0;
        bif.rx_stb  = 1'b0;
        ack_dly     = 0;
        rdata_val   = '0;
        repeat (3) @(negedge clk);
        check("reset bus_req", bif.bus_req, 0);
        check("reset tx_req", bif.tx_req, 0);
        check("reset busy", bif.busy, 0);
        check("reset rx_drop", bif.rx_drop, 0);
        check("reset tx_byte", bif.tx_byte, 0);
        check("reset bus_we/addr/wdata", {bif.bus_we, bif.bus_addr, bif.bus_wdata}, 0);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Bytes arriving during a read reply are dropped without disturbing it
        txq.delete();
        drops     = 0;
        viol      = 0;
        rdata_val = 32'hDEAD_BEEF;
        ack_dly   = 0;
        send(8'h52);
        send(8'h20);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txq.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("drop reply started", ok, 1);
        send(8'h57);
        send(8'h10);
        wait_done(4, ok);
        check("drop done", ok, 1);
        check("drop pulses", drops, 2);
        check_tx("drop", 32'hDEAD_BEEF);
        check("drop pacing", viol, 0);
        v = '{48'h0000_0000_2052, 2, 32'h1122_3344, 2, 1'b1, 1'b0, 8'h20, 32'h0, 4, 32'h1122_3344};
        run_vec(v, "after-drop");

        // Asynchronous reset while a write is on the bus
        txq.delete();
        req_seen = 1'b0;
        ack_dly  = 100000;
        send(8'h57);
        send(8'h10);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bif.bus_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid-write bus_req", ok, 1);
        rst_ = 1'b0;
        #1;
        check("async rst bus_req", bif.bus_req, 0);
        check("async rst tx_req", bif.tx_req, 0);
        check("async rst busy", bif.busy, 0);
        check("async rst bus_we/addr/wdata", {bif.bus_we, bif.bus_addr, bif.bus_wdata}, 0);
        check("async rst tx_byte/rx_drop", {bif.tx_byte, bif.rx_drop}, 0);
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);
        check("after rst no tx", txq.size(), 0);
        v = '{48'h5566_7788_1057, 6, 32'h0, 2, 1'b1, 1'b1, 8'h10, 32'h5566_7788, 1, 32'h06};
        run_vec(v, "after-rst");

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Partial write abandoned by the inter-byte timeout
        txq.delete();
        req_seen = 1'b0;
        ack_dly  = 0;
        send(8'h57);
        send(8'h10);
        send(8'h01);
        repeat (90) @(negedge clk);
        check("tmo still waiting", bif.busy, 1);
        repeat (20) @(negedge clk);
        check("tmo back to idle", bif.busy, 0);
        check("tmo no bus_req", req_seen, 0);
        check("tmo no tx", txq.size(), 0);
        v = '{48'h0000_0000_2052, 2, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 8'h20, 32'h0, 4, 32'hCAFE_F00D};
        run_vec(v, "after-tmo");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
